// File: rtl/prog_loader.sv
// Program loader: accepts a framed byte stream [count][4*N bytes LE][xor] and writes
// 32-bit words into program memory while holding the CPU.
module prog_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 2500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [31:0]       prog_data,
  output logic              prog_wren,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int TW = $clog2(TIMEOUT + 1);

  // Byte handshake: a byte moves on any rising edge where byte_valid && byte_ready.
  // byte_ready depends only on the registered state, never on byte_valid.
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
  logic [31:0]       prog_data_q, prog_data_d;

  logic              xfer;
  logic [TW-1:0]     timer_inc;
  logic              timeout_hit;
  logic [ADDR_W:0]   words_inc;
  logic [31:0]       word_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      words_q     <= '0;
      word_q      <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      timer_q     <= '0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      words_q     <= words_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      timer_q     <= timer_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    words_d     = words_q;
    word_d      = word_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    timer_d     = timer_q;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;

    byte_ready  = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
    xfer        = byte_valid && byte_ready;
    timer_inc   = timer_q + 1'b1;
    timeout_hit = (timer_inc == TW'(TIMEOUT));
    words_inc   = words_q + 1'b1;

    word_next = word_q;
    case (idx_q)
      2'd0:    word_next[7:0]   = byte_data;
      2'd1:    word_next[15:8]  = byte_data;
      2'd2:    word_next[23:16] = byte_data;
      default: word_next[31:24] = byte_data;
    endcase

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
          words_d = '0;
          csum_d  = '0;
          addr_d  = base_addr;
          idx_d   = '0;
          timer_d = '0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          // A zero count means a full sweep of the address space.
          count_d = (byte_data == 8'd0) ? {1'b1, {ADDR_W{1'b0}}} : (ADDR_W+1)'(byte_data);
          csum_d  = csum_q ^ byte_data;
          timer_d = '0;
          state_d = S_DATA;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d  = word_next;
          csum_d  = csum_q ^ byte_data;
          timer_d = '0;
          idx_d   = idx_q + 1'b1;
          if (idx_q == 2'd3) begin
            state_d     = S_WRITE;
            prog_addr_d = addr_q;
            prog_data_d = word_next;
          end
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 1'b1;
        words_d = words_inc;
        state_d = (words_inc == count_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (xfer) begin
          timer_d = '0;
          state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign prog_addr    = prog_addr_q;
  assign prog_data    = prog_data_q;
  assign prog_wren    = (state_q == S_WRITE);
  assign cpu_hold     = (state_q == S_HDR) || (state_q == S_DATA) ||
                        (state_q == S_WRITE) || (state_q == S_CSUM);
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_ERR);
  assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frames are built from word lists, expected writes and
// final status come from a frame-level model; one negedge process checks writes.
module tb_prog_loader;
  localparam int ADDR_W = 8;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] prog_addr;
  logic [31:0]       prog_data;
  logic              prog_wren;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_wren(prog_wren),
    .cpu_hold(cpu_hold), .done(done), .err(err), .words_loaded(words_loaded)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;
  int wren_cnt = 0;
  bit chk_en = 1'b0;
  logic [ADDR_W+31:0] exp_q[$];   // {addr, data} of every write still owed
  logic [31:0] words[256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: every write strobe must match the oldest owed write
  always @(negedge clk) begin
    if (chk_en) begin
      check("done_err_exclusive", {63'd0, done & err}, 64'd0);
      if (prog_wren) begin
        wren_cnt++;
        check("hold_during_write", {63'd0, cpu_hold}, 64'd1);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", prog_addr, prog_data);
        end else begin
          logic [ADDR_W+31:0] e;
          e = exp_q.pop_front();
          check("write_addr", {56'd0, prog_addr}, {56'd0, e[ADDR_W+31:32]});
          check("write_data", {32'd0, prog_data}, {32'd0, e[31:0]});
        end
      end
    end
  end

  // model: xor over count byte and all data bytes
  function automatic logic [7:0] frame_xor(input int n);
    logic [7:0] x;
    x = 8'(n);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) x ^= words[i][8*k +: 8];
    return x;
  endfunction

  // driver tasks: all begin and end just after a falling edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (!byte_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) begin
      tests++;
      fails++;
      $display("FAIL byte_accept: byte 0x%0h not accepted within 100 cycles, required acceptance", b);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic pulse_start(input logic [7:0] base);
    start     = 1'b1;
    base_addr = base;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] base, input int n, input bit force_csum,
                           input logic [7:0] csum_byte, input int maxgap, input bit poke_start);
    logic [7:0] model_x, last;
    logic [7:0] a;
    pulse_start(base);
    check("start_clears_done", {63'd0, done}, 64'd0);
    check("start_clears_err", {63'd0, err}, 64'd0);
    check("start_clears_words", {55'd0, words_loaded}, 64'd0);
    check("hold_after_start", {63'd0, cpu_hold}, 64'd1);
    for (int i = 0; i < n; i++) begin
      a = base + 8'(i);
      exp_q.push_back({a, words[i]});
    end
    model_x = frame_xor(n);
    last = force_csum ? csum_byte : model_x;
    send_byte(8'(n), $urandom_range(0, maxgap));
    if (poke_start) begin
      start     = 1'b1;
      base_addr = ~base;
    end
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) begin
        send_byte(words[i][8*k +: 8], $urandom_range(0, maxgap));
        start = 1'b0;
      end
    send_byte(last, $urandom_range(0, maxgap));
    byte_valid = 1'b0;
    check("final_done", {63'd0, done}, {63'd0, last == model_x});
    check("final_err", {63'd0, err}, {63'd0, last != model_x});
    check("final_hold", {63'd0, cpu_hold}, 64'd0);
    check("final_words", {55'd0, words_loaded}, 64'(n));
    check("all_writes_seen", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int w0;
    rst = 1'b1; start = 1'b0; base_addr = '0; byte_data = '0; byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, byte_ready}, 64'd0);
    check("rst_addr", {56'd0, prog_addr}, 64'd0);
    check("rst_data", {32'd0, prog_data}, 64'd0);
    check("rst_wren", {63'd0, prog_wren}, 64'd0);
    check("rst_hold", {63'd0, cpu_hold}, 64'd0);
    check("rst_done_err", {62'd0, done, err}, 64'd0);
    check("rst_words", {55'd0, words_loaded}, 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // T1: single word, hand-computed checksum 01^13^00^50^00 = 42
    words[0] = 32'h0050_0013;
    check("t1_model_xor", {56'd0, frame_xor(1)}, 64'h42);
    run_frame(8'h10, 1, 1'b1, 8'h42, 0, 1'b0);
    check("t1_last_addr", {56'd0, prog_addr}, 64'h10);
    check("t1_last_data", {32'd0, prog_data}, 64'h0050_0013);

    // T2: two words in order, exactly two write strobes
    words[0] = 32'h0000_0093;
    words[1] = 32'h0010_8113;
    check("t2_model_xor", {56'd0, frame_xor(2)}, 64'h13);
    w0 = wren_cnt;
    run_frame(8'h20, 2, 1'b1, 8'h13, 0, 1'b1);
    check("t2_wren_cycles", 64'(wren_cnt - w0), 64'd2);

    // T3: bad checksum still writes, ends in error
    words[0] = 32'h0050_0013;
    run_frame(8'h10, 1, 1'b1, 8'h00, 0, 1'b0);

    // T4: stall after two data bytes; error lands exactly TMO idle cycles later
    pulse_start(8'h30);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    byte_valid = 1'b0;
    repeat (TMO - 1) @(negedge clk);
    check("t4_not_early", {63'd0, err}, 64'd0);
    check("t4_hold_waiting", {63'd0, cpu_hold}, 64'd1);
    @(negedge clk);
    check("t4_err", {63'd0, err}, 64'd1);
    check("t4_done", {63'd0, done}, 64'd0);
    check("t4_hold_off", {63'd0, cpu_hold}, 64'd0);
    check("t4_words", {55'd0, words_loaded}, 64'd0);

    // T5: address wrap with byte_valid held continuously through WRITE
    words[0] = $urandom();
    words[1] = $urandom();
    run_frame(8'hFF, 2, 1'b0, 8'h00, 0, 1'b0);

    // T6: reset after the first of three writes
    for (int i = 0; i < 3; i++) words[i] = $urandom();
    pulse_start(8'h40);
    exp_q.push_back({8'h40, words[0]});
    send_byte(8'h03, 0);
    for (int k = 0; k < 4; k++) send_byte(words[0][8*k +: 8], 0);
    send_byte(words[1][7:0], 0);
    send_byte(words[1][15:8], 0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_addr", {56'd0, prog_addr}, 64'd0);
    check("t6_data", {32'd0, prog_data}, 64'd0);
    check("t6_wren", {63'd0, prog_wren}, 64'd0);
    check("t6_hold", {63'd0, cpu_hold}, 64'd0);
    check("t6_ready", {63'd0, byte_ready}, 64'd0);
    check("t6_words", {55'd0, words_loaded}, 64'd0);
    check("t6_first_write_seen", 64'(exp_q.size()), 64'd0);
    rst = 1'b0;
    byte_data = words[1][23:16];
    repeat (10) @(negedge clk);
    check("t6_ready_idle", {63'd0, byte_ready}, 64'd0);
    byte_valid = 1'b0;
    run_frame(8'h50, 3, 1'b0, 8'h00, 1, 1'b0);

    // full sweep: count byte 0 means 256 words
    for (int i = 0; i < 256; i++) words[i] = $urandom();
    run_frame(8'($urandom_range(0, 255)), 256, 1'b0, 8'h00, 0, 1'b0);

    // random frames with random gaps, corruption and ignored start pulses
    for (int r = 0; r < 10; r++) begin
      int n;
      bit bad;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) words[i] = $urandom();
      bad = ($urandom_range(0, 3) == 0);
      run_frame(8'($urandom_range(0, 255)), n, bad, frame_xor(n) ^ 8'($urandom_range(1, 255)),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
